// File: rtl/bram_fwft_fifo_ctrl.sv
// ----------------------------------------------------------------------------
// bram_fwft_fifo_ctrl
//
// Single-clock first-word-fall-through FIFO controller wrapped around a
// simple-dual-port block RAM whose read data is registered (DEL = 1 or 2
// cycles from ram_ren to ram_rda). The RAM read latency is hidden behind a
// small register prefetch buffer of DEL+1 entries, so the consumer sees a
// plain valid/pop FWFT interface.
//
// Ports
//   clk, rst        sole clock (also both RAM clocks), async active-high reset
//   clr             synchronous flush, same effect as rst at the clock edge
//   push, din       write request / data; ignored while full
//   full            RAM store full (RAM occupancy only)
//   pop             consumer takes dout this cycle
//   dout, valid     head-of-queue data / head present
//   level           total entries held: RAM + in flight + prefetch buffer
//   ovf, udf        one-cycle pulses: push while full / pop while !valid
//   ram_wen/wad/wda RAM write port (combinational from push)
//   ram_ren/rad     RAM read port (combinational issue)
//   ram_rrst        RAM output-register reset, rst | clr
//   ram_rda         RAM read data, DEL cycles after ram_ren
// ----------------------------------------------------------------------------
module bram_fwft_fifo_ctrl #(
    parameter int ADR = 8,
    parameter int DAT = 9,
    parameter int DEP = 256,
    parameter int DEL = 1
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           clr,
    input  logic           push,
    input  logic [DAT-1:0] din,
    output logic           full,
    input  logic           pop,
    output logic [DAT-1:0] dout,
    output logic           valid,
    output logic [ADR+1:0] level,
    output logic           ovf,
    output logic           udf,
    output logic           ram_wen,
    output logic [ADR-1:0] ram_wad,
    output logic [DAT-1:0] ram_wda,
    output logic           ram_ren,
    output logic [ADR-1:0] ram_rad,
    output logic           ram_rrst,
    input  logic [DAT-1:0] ram_rda
);

    localparam int NBUF = DEL + 1;
    localparam int BCW  = $clog2(NBUF + 1);

    logic [ADR:0]     r_wr_ptr;
    logic [ADR:0]     r_rd_ptr;
    logic [DEL-1:0]   r_ren_sr;
    logic [DAT-1:0]   r_buf [NBUF];
    logic [BCW-1:0]   r_buf_cnt;
    logic             r_ovf;
    logic             r_udf;

    logic             w_flush;
    logic [ADR:0]     w_ram_cnt;
    logic             w_full;
    logic             w_valid;
    logic             w_push_acc;
    logic             w_pop_acc;
    logic             w_issue;
    logic             w_land;
    logic [BCW-1:0]   w_inflight;
    logic [BCW:0]     w_commit;
    logic [BCW-1:0]   w_tail;
    logic [DAT-1:0]   w_buf_nxt [NBUF];
    logic [BCW-1:0]   w_buf_cnt_nxt;

    // Requests arriving while the controller is being flushed are dropped so
    // nothing reaches the RAM ports during rst or clr.
    assign w_flush    = rst | clr;
    assign w_ram_cnt  = r_wr_ptr - r_rd_ptr;
    assign w_full     = (w_ram_cnt == (ADR+1)'(DEP));
    assign w_valid    = (r_buf_cnt != '0);
    assign w_push_acc = push & ~w_full & ~w_flush;
    assign w_pop_acc  = pop & w_valid & ~w_flush;
    assign w_land     = r_ren_sr[DEL-1];

    always_comb begin
        w_inflight = '0;
        for (int i = 0; i < DEL; i++) begin
            w_inflight = w_inflight + BCW'(r_ren_sr[i]);
        end
    end

    // Entries committed to the buffer once everything in flight has landed.
    // Issuing only while this stays below DEL+1 guarantees a free slot for
    // every word coming out of the RAM pipeline.
    assign w_commit = {1'b0, w_inflight} + {1'b0, r_buf_cnt} - (BCW+1)'(w_pop_acc);
    assign w_issue  = (w_ram_cnt != '0) && (w_commit < (BCW+1)'(NBUF)) && ~w_flush;

    // Prefetch buffer is a shift-down register FIFO: head always in slot 0,
    // a landing word goes to the first free slot after this cycle's pop.
    always_comb begin
        w_buf_nxt = r_buf;
        w_tail    = r_buf_cnt;
        if (w_pop_acc) begin
            for (int i = 0; i < NBUF - 1; i++) begin
                w_buf_nxt[i] = r_buf[i+1];
            end
            w_tail = r_buf_cnt - BCW'(1);
        end
        if (w_land) begin
            for (int i = 0; i < NBUF; i++) begin
                if (w_tail == BCW'(i)) begin
                    w_buf_nxt[i] = ram_rda;
                end
            end
        end
        w_buf_cnt_nxt = w_tail + BCW'(w_land);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_ren_sr  <= '0;
            r_buf_cnt <= '0;
            r_ovf     <= 1'b0;
            r_udf     <= 1'b0;
            for (int i = 0; i < NBUF; i++) begin
                r_buf[i] <= '0;
            end
        end else if (clr) begin
            // Clearing the in-flight shift register discards any read data
            // still coming out of the RAM.
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_ren_sr  <= '0;
            r_buf_cnt <= '0;
            r_ovf     <= 1'b0;
            r_udf     <= 1'b0;
            for (int i = 0; i < NBUF; i++) begin
                r_buf[i] <= '0;
            end
        end else begin
            if (w_push_acc) begin
                r_wr_ptr <= r_wr_ptr + (ADR+1)'(1);
            end
            if (w_issue) begin
                r_rd_ptr <= r_rd_ptr + (ADR+1)'(1);
            end
            r_ren_sr  <= DEL'({r_ren_sr, w_issue});
            r_buf     <= w_buf_nxt;
            r_buf_cnt <= w_buf_cnt_nxt;
            r_ovf     <= push & w_full;
            r_udf     <= pop & ~w_valid;
        end
    end

    assign full     = w_full;
    assign valid    = w_valid;
    assign dout     = r_buf[0];
    assign level    = (ADR+2)'(w_ram_cnt) + (ADR+2)'(w_inflight) + (ADR+2)'(r_buf_cnt);
    assign ovf      = r_ovf;
    assign udf      = r_udf;

    assign ram_wen  = w_push_acc;
    assign ram_wad  = r_wr_ptr[ADR-1:0];
    assign ram_wda  = din;
    assign ram_ren  = w_issue;
    assign ram_rad  = r_rd_ptr[ADR-1:0];
    assign ram_rrst = w_flush;

endmodule

// File: tb/tb_bram_fwft_fifo_ctrl.sv
// Two controllers (DEL=1 and DEL=2, 16-deep RAM) share one stimulus stream.
// Accepted pushes go into a per-instance expected queue stamped with their
// push cycle; a negedge monitor checks level, valid timing, data order and
// the ovf/udf pulses against that queue.
module tb_bram_fwft_fifo_ctrl;

    localparam int ADR  = 4;
    localparam int DAT  = 9;
    localparam int DEP  = 16;
    localparam int DEL0 = 1;
    localparam int DEL1 = 2;

    typedef struct {
        logic [8:0] d;
        int         c;
    } ent_t;

    logic       clk = 1'b0;
    logic       rst, clr, push, pop;
    logic [8:0] din;
    logic [1:0] full, valid, ovf, udf, wen, ren, rrst;
    logic [8:0] dout [2];
    logic [8:0] wda  [2];
    logic [8:0] rda  [2];
    logic [5:0] level [2];
    logic [3:0] wad  [2];
    logic [3:0] rad  [2];

    logic [8:0] mem0 [16];
    logic [8:0] mem1 [16];
    logic [8:0] rq0, rq1a, rq1b;

    ent_t       sbq [2][$];
    logic [1:0] pacc = 2'b00;
    logic [1:0] exp_ovf = 2'b00;
    logic [1:0] exp_udf = 2'b00;
    int         cyc = 0;
    int         checks = 0;
    int         failures = 0;
    int         mn;
    logic       mev;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    bram_fwft_fifo_ctrl #(.ADR(ADR), .DAT(DAT), .DEP(DEP), .DEL(DEL0)) u_dut0 (
        .clk(clk), .rst(rst), .clr(clr), .push(push), .din(din), .full(full[0]),
        .pop(pop), .dout(dout[0]), .valid(valid[0]), .level(level[0]),
        .ovf(ovf[0]), .udf(udf[0]), .ram_wen(wen[0]), .ram_wad(wad[0]),
        .ram_wda(wda[0]), .ram_ren(ren[0]), .ram_rad(rad[0]),
        .ram_rrst(rrst[0]), .ram_rda(rda[0])
    );

    bram_fwft_fifo_ctrl #(.ADR(ADR), .DAT(DAT), .DEP(DEP), .DEL(DEL1)) u_dut1 (
        .clk(clk), .rst(rst), .clr(clr), .push(push), .din(din), .full(full[1]),
        .pop(pop), .dout(dout[1]), .valid(valid[1]), .level(level[1]),
        .ovf(ovf[1]), .udf(udf[1]), .ram_wen(wen[1]), .ram_wad(wad[1]),
        .ram_wda(wda[1]), .ram_ren(ren[1]), .ram_rad(rad[1]),
        .ram_rrst(rrst[1]), .ram_rda(rda[1])
    );

    // Behavioural SDP RAMs with one and two output register stages.
    always @(posedge clk) begin
        if (wen[0]) mem0[wad[0]] <= wda[0];
        if (rrst[0]) rq0 <= '0;
        else if (ren[0]) rq0 <= mem0[rad[0]];
    end
    always @(posedge clk) begin
        if (wen[1]) mem1[wad[1]] <= wda[1];
        if (rrst[1]) begin
            rq1a <= '0;
            rq1b <= '0;
        end else begin
            if (ren[1]) rq1a <= mem1[rad[1]];
            rq1b <= rq1a;
        end
    end
    assign rda[0] = rq0;
    assign rda[1] = rq1b;

    function automatic int dl(input int k);
        return (k == 0) ? DEL0 : DEL1;
    endfunction

    task automatic chk(input string nm, input int k, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s dut%0d cyc=%0d: got %0h expected %0h", nm, k, cyc, act, exp);
        end
    endtask

    // Monitor: the model level is the queue size minus the push issued this
    // cycle (it is registered only at the coming edge). A word pushed in
    // cycle p reaches the head no earlier and no later than p+DEL+2.
    always @(negedge clk) begin
        if (rst) begin
            exp_ovf = 2'b00;
            exp_udf = 2'b00;
        end else begin
            for (int k = 0; k < 2; k++) begin
                mn  = sbq[k].size() - int'(pacc[k]);
                mev = (mn > 0) && (cyc >= sbq[k][0].c + dl(k) + 2);
                chk("valid", k, valid[k], mev);
                chk("level", k, level[k], mn);
                chk("ovf", k, ovf[k], exp_ovf[k]);
                chk("udf", k, udf[k], exp_udf[k]);
                if (mn < DEP) chk("full_low", k, full[k], 0);
                if (mn == DEP + dl(k) + 1) chk("full_cap", k, full[k], 1);
                if (clr) begin
                    sbq[k].delete();
                end else if (pop && valid[k] && mn > 0) begin
                    chk("dout", k, dout[k], sbq[k][0].d);
                    void'(sbq[k].pop_front());
                end
                exp_ovf[k] = push && full[k] && !clr;
                exp_udf[k] = pop && !mev && !clr;
            end
        end
    end

    task automatic apply(input logic p, input logic [8:0] dv, input logic q, input logic c);
        ent_t e;
        push = p;
        din  = dv;
        pop  = q;
        clr  = c;
        for (int k = 0; k < 2; k++) begin
            pacc[k] = p && !full[k] && !c;
            if (pacc[k]) begin
                e.d = dv;
                e.c = cyc;
                sbq[k].push_back(e);
            end
        end
    endtask

    task automatic drive(input logic p, input logic [8:0] dv, input logic q, input logic c);
        @(posedge clk);
        #1;
        apply(p, dv, q, c);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 9'h0, 1'b0, 1'b0);
    endtask

    int         peak;
    int         pushed;
    int         flagbad;
    logic       rp, rqq;

    initial begin
        rst  = 1'b1;
        clr  = 1'b0;
        push = 1'b1;
        pop  = 1'b1;
        din  = 9'h1FF;
        repeat (3) @(posedge clk);
        #2;
        for (int k = 0; k < 2; k++) begin
            chk("rst_full", k, full[k], 0);
            chk("rst_valid", k, valid[k], 0);
            chk("rst_level", k, level[k], 0);
            chk("rst_ovf", k, ovf[k], 0);
            chk("rst_udf", k, udf[k], 0);
            chk("rst_wen", k, wen[k], 0);
            chk("rst_ren", k, ren[k], 0);
            chk("rst_dout", k, dout[k], 0);
        end
        push = 1'b0;
        pop  = 1'b0;
        #1 rst = 1'b0;

        // Single word latency.
        drive(1'b1, 9'h1A5, 1'b0, 1'b0);
        #1;
        for (int k = 0; k < 2; k++) begin
            chk("t1_wen", k, wen[k], 1);
            chk("t1_wad", k, wad[k], 0);
            chk("t1_wda", k, wda[k], 9'h1A5);
        end
        drive(1'b0, 9'h0, 1'b0, 1'b0);
        #1;
        for (int k = 0; k < 2; k++) begin
            chk("t1_ren", k, ren[k], 1);
            chk("t1_rad", k, rad[k], 0);
        end
        idle(8);
        for (int k = 0; k < 2; k++) begin
            chk("t1_level", k, level[k], 1);
            chk("t1_dout", k, dout[k], 9'h1A5);
        end
        drive(1'b0, 9'h0, 1'b1, 1'b0);
        idle(2);

        // Fill past capacity, then drain in order.
        for (int i = 0; i < 20; i++) drive(1'b1, 9'(i), 1'b0, 1'b0);
        idle(4);
        chk("t2_level", 0, level[0], 18);
        chk("t2_level", 1, level[1], 19);
        chk("t2_full", 0, full[0], 1);
        chk("t2_full", 1, full[1], 1);
        for (int i = 0; i < 25; i++) drive(1'b0, 9'h0, 1'b1, 1'b0);
        idle(2);
        for (int k = 0; k < 2; k++) chk("t2_empty", k, level[k], 0);

        // Streaming push and pop every cycle.
        peak = 0;
        for (int i = 0; i < 100; i++) begin
            drive(1'b1, 9'(i), 1'b1, 1'b0);
            if (int'(level[1]) > peak) peak = int'(level[1]);
        end
        chk("t3_peak_le4", 1, (peak <= 4), 1);
        for (int i = 0; i < 8; i++) drive(1'b0, 9'h0, 1'b1, 1'b0);

        // Pop while empty.
        idle(2);
        drive(1'b0, 9'h0, 1'b1, 1'b0);
        drive(1'b0, 9'h0, 1'b0, 1'b0);
        #1;
        for (int k = 0; k < 2; k++) begin
            chk("t4_udf", k, udf[k], 1);
            chk("t4_level", k, level[k], 0);
            chk("t4_valid", k, valid[k], 0);
        end

        // Flush while a read is in flight.
        drive(1'b1, 9'h101, 1'b0, 1'b0);
        drive(1'b1, 9'h102, 1'b0, 1'b0);
        drive(1'b1, 9'h103, 1'b0, 1'b1);
        drive(1'b0, 9'h0, 1'b0, 1'b0);
        #1;
        for (int k = 0; k < 2; k++) begin
            chk("t5_level", k, level[k], 0);
            chk("t5_valid", k, valid[k], 0);
        end
        idle(5);
        drive(1'b1, 9'h0AA, 1'b0, 1'b0);
        idle(6);
        for (int k = 0; k < 2; k++) chk("t5_dout", k, dout[k], 9'h0AA);
        drive(1'b0, 9'h0, 1'b1, 1'b0);
        idle(2);

        // Random rates across two pointer wraps.
        pushed  = 0;
        flagbad = 0;
        for (int t = 0; t < 600 && pushed < 40; t++) begin
            @(posedge clk);
            #1;
            if (ovf != 2'b00 || udf != 2'b00) flagbad++;
            rp  = ($urandom_range(0, 1) == 1) && !full[0] && !full[1];
            rqq = ($urandom_range(0, 2) != 0) && valid[0] && valid[1];
            apply(rp, 9'($urandom_range(0, 511)), rqq, 1'b0);
            if (rp) pushed++;
        end
        chk("t6_pushed", 0, pushed, 40);
        for (int i = 0; i < 30; i++) begin
            @(posedge clk);
            #1;
            if (ovf != 2'b00 || udf != 2'b00) flagbad++;
            apply(1'b0, 9'h0, valid[0] && valid[1], 1'b0);
        end
        chk("t6_flags", 0, flagbad, 0);
        idle(3);
        for (int k = 0; k < 2; k++) begin
            chk("t6_level", k, level[k], 0);
            chk("t6_sb_empty", k, sbq[k].size(), 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, got timeout expected finish");
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/bram_fwft_fifo_ctrl.md
Name: bram_fwft_fifo_ctrl

Overview:
Single-clock first-word-fall-through FIFO controller that sits directly upstream of and around a simple-dual-port block RAM with registered read data (RAM_DEL = 1 or 2 cycles).
- It owns the RAM write and read ports and hides the RAM read latency behind a small register prefetch buffer.
- It presents a valid/pop FWFT interface to the consumer, with occupancy and error flags.
- The RAM's two clock pins are both tied to clk by the instantiating level.

Parameters:
ADR, 8, RAM address width.
DAT, 9, data width.
DEP, 256, RAM depth; must equal 2**ADR.
DEL, 1, RAM read latency in cycles, from ram_ren to ram_rda valid; legal values 1 or 2.

Ports:
clk  in  1  sole clock; also drives both RAM clock pins.
rst  in  1  asynchronous, active-high reset.
clr  in  1  synchronous flush; same effect as rst, applied at the clock edge.
push  in  1  write request.
din  in  DAT  write data.
full  out  1  RAM store full; push is ignored while high.
pop  in  1  consumer takes dout this cycle.
dout  out  DAT  head-of-queue data; meaningful only when valid=1.
valid  out  1  head entry present (FWFT).
level  out  ADR+2  total entries held: RAM + in flight + prefetch buffer.
ovf  out  1  one-cycle pulse: push while full.
udf  out  1  one-cycle pulse: pop while valid=0.
ram_wen  out  1  RAM write enable.
ram_wad  out  ADR  RAM write address.
ram_wda  out  DAT  RAM write data.
ram_ren  out  1  RAM read enable.
ram_rad  out  ADR  RAM read address.
ram_rrst  out  1  RAM output-register reset; equals rst|clr.
ram_rda  in  DAT  RAM read data, DEL cycles after ram_ren.

Behaviour:
- Reset (rst async, or clr sync): wr_ptr=rd_ptr=0, in-flight shift register cleared, prefetch buffer emptied.
  - Reset values: full=0, valid=0, level=0, ovf=0, udf=0, ram_wen=0, ram_ren=0, dout=0.
- Pointers are ADR+1 bits; the MSB is the wrap bit.
  - ram_cnt = wr_ptr - rd_ptr.
  - full = (ram_cnt == DEP); flag is combinational from registered pointers.
- Push accepted when push & !full:
  - ram_wen=1, ram_wad=wr_ptr[ADR-1:0], ram_wda=din, same cycle (combinational).
  - wr_ptr increments at the edge.
- Push & full: no write; ovf=1 next cycle.
- Prefetch buffer: register FIFO of DEL+1 entries; buf_cnt 0..DEL+1.
  - dout = buffer head; valid = (buf_cnt != 0).
  - Pop accepted (pop_acc) when pop & valid; head advances at the edge.
  - Pop & !valid: no state change; udf=1 next cycle.
- Read issue:
  - Condition: ram_cnt != 0 && (inflight + buf_cnt - pop_acc) < DEL+1.
  - On issue: ram_ren=1, ram_rad=rd_ptr[ADR-1:0]; rd_ptr increments at the edge.
  - inflight = number of 1s in a DEL-bit shift register of ram_ren.
  - When that bit exits the shift register, ram_rda is written into the buffer tail in the same cycle.
  - The issue rule guarantees buffer space; the buffer never overflows.
- Collision safety: a read only targets addresses written at least one cycle earlier. A slot freed by rd_ptr increment is writable from the next cycle.
- Latency: push in cycle N with queue empty gives valid=1 in cycle N+DEL+2.
- Throughput: sustained push&pop streams 1 word/cycle with no valid gaps once primed.
- Capacity: DEP+DEL+1 entries total. full reflects RAM only; level reports the total.
- Simultaneous push & pop: both are processed independently in the same cycle. level changes by (push_acc - pop_acc).
- clr or rst while reads are in flight: the shift register is cleared, so late ram_rda is discarded. ram_rrst clears the RAM output register.
- Ordering: strict FIFO across pointer wrap.

Test Plan:
1. ADR=4, DEP=16, DEL=1; push 0x1A5 in cycle 0 -> ram_wen/ram_wad=0 in cycle 0, ram_ren in cycle 1, valid=1 with dout=0x1A5 in cycle 3, level=1.
2. DEL=1; 19 pushes, no pop -> full rises after push 18 (16 in RAM, 2 in buffer), level=18; push 19 ignored with ovf pulse; 18 pops return 0..17 in order, then valid=0, level=0.
3. DEL=2; push and pop every cycle for 100 words (values 0..99) -> first valid in cycle 4, then valid held high with no gaps, in-order data, level steady at 4 or less.
4. Pop with queue empty -> udf pulses one cycle; level, valid and pointers unchanged.
5. DEL=2; push 5 words, assert clr the cycle after the first ram_ren -> next cycle level=0, valid=0; the stale ram_rda never appears on dout; new push 0x0AA emerges correctly.
6. DEP=16; 40 words pushed and popped at random rates -> pointers wrap twice, zero data loss, correct order, ovf=udf=0 throughout.
